// File: rtl/resource_instr_issuer.sv
// ---------------------------------------------------------------------------
// resource_instr_issuer
//
// Purpose:
//    Buffers instruction words and activate requests from the sequencer in a
//    small FIFO and replays them, strictly in order, onto the resource-side
//    instruction interface. Instructions become one-cycle instr_en pulses with
//    the payload on instr. Activates become one-cycle activate pulses. Each
//    activate is followed by ACT_GAP quiet cycles so the resources can latch
//    their configuration before the next instruction arrives.
//
// Ports:
//    clk        in   clock
//    rst_n      in   asynchronous active-low reset
//    in_valid   in   sequencer presents an entry
//    in_ready   out  issuer accepts the entry this cycle (FIFO not full)
//    in_is_act  in   1 = activate request, 0 = instruction
//    in_instr   in   instruction payload (ignored for activates)
//    hold       in   freezes issuing while buffering continues
//    instr_en   out  one-cycle strobe qualifying instr
//    instr      out  instruction word, zero whenever instr_en is low
//    activate   out  one-cycle activate strobe
//    count      out  current FIFO occupancy
//    idle       out  FIFO empty, FSM idle and no strobe asserted
// ---------------------------------------------------------------------------
module resource_instr_issuer #(
   parameter int RESOURCE_INSTR_WIDTH = 27,
   parameter int FIFO_DEPTH           = 4,
   parameter int ACT_GAP              = 2
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              in_valid,
   output logic                              in_ready,
   input  logic                              in_is_act,
   input  logic [RESOURCE_INSTR_WIDTH-1:0]   in_instr,
   input  logic                              hold,
   output logic                              instr_en,
   output logic [RESOURCE_INSTR_WIDTH-1:0]   instr,
   output logic                              activate,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]   count,
   output logic                              idle
);

   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int GW = (ACT_GAP > 0) ? $clog2(ACT_GAP + 1) : 1;
   localparam int EW = RESOURCE_INSTR_WIDTH + 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_GAP
   } state_t;

   state_t                          r_state;
   state_t                          w_stateNext;
   logic [EW-1:0]                   r_mem [FIFO_DEPTH];
   logic [PW-1:0]                   r_wrPtr;
   logic [PW-1:0]                   r_rdPtr;
   logic [CW-1:0]                   r_count;
   logic [GW-1:0]                   r_gapCnt;
   logic [GW-1:0]                   w_gapCntNext;
   logic                            r_instrEn;
   logic                            r_activate;
   logic [RESOURCE_INSTR_WIDTH-1:0] r_instr;
   logic                            w_push;
   logic                            w_pop;
   logic [EW-1:0]                   w_head;
   logic                            w_headIsAct;

   // Ready depends on occupancy alone, so a full FIFO refuses a push even
   // when a pop happens on the same edge.
   assign in_ready    = (r_count < CW'(FIFO_DEPTH));
   assign w_push      = in_valid && in_ready;
   assign w_head      = r_mem[r_rdPtr];
   assign w_headIsAct = w_head[EW-1];

   assign instr_en = r_instrEn;
   assign instr    = r_instr;
   assign activate = r_activate;
   assign count    = r_count;
   assign idle     = (r_count == '0) && (r_state == ST_IDLE) && !r_instrEn && !r_activate;

   // Storage array carries no reset: stale entries are never read because
   // the pointers and occupancy are cleared.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wrPtr] <= {in_is_act, in_instr};
      end
   end

   // Pointers wrap naturally since the depth is a power of two; occupancy
   // moves by +1, -1 or 0 depending on which of push/pop happen together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_wrPtr <= r_wrPtr + PW'(1);
         end
         if (w_pop) begin
            r_rdPtr <= r_rdPtr + PW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Next-state and pop decision. IDLE and ISSUE share the same pop rule so
   // back-to-back instructions stream one per cycle. An activate enters GAP
   // loaded with ACT_GAP; GAP returns to IDLE on the edge where the counter
   // runs out, which yields exactly ACT_GAP silent cycles after the pulse.
   always_comb begin
      w_stateNext  = r_state;
      w_gapCntNext = r_gapCnt;
      w_pop        = 1'b0;
      case (r_state)
         ST_IDLE, ST_ISSUE: begin
            if ((r_count != '0) && !hold) begin
               w_pop       = 1'b1;
               w_stateNext = ST_ISSUE;
               if (w_headIsAct && (ACT_GAP != 0)) begin
                  w_stateNext  = ST_GAP;
                  w_gapCntNext = GW'(ACT_GAP);
               end
            end else begin
               w_stateNext = ST_IDLE;
            end
         end
         ST_GAP: begin
            w_gapCntNext = r_gapCnt - GW'(1);
            if (r_gapCnt <= GW'(1)) begin
               w_stateNext = ST_IDLE;
            end
         end
         default: begin
            w_stateNext = ST_IDLE;
         end
      endcase
   end

   // State register plus the registered strobes. The strobes are recomputed
   // from the pop every edge, so each lasts exactly one cycle and the two
   // can never be high together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_gapCnt   <= '0;
         r_instrEn  <= 1'b0;
         r_activate <= 1'b0;
         r_instr    <= '0;
      end else begin
         r_state    <= w_stateNext;
         r_gapCnt   <= w_gapCntNext;
         r_instrEn  <= w_pop && !w_headIsAct;
         r_activate <= w_pop && w_headIsAct;
         r_instr    <= (w_pop && !w_headIsAct) ? w_head[RESOURCE_INSTR_WIDTH-1:0] : '0;
      end
   end

endmodule

// File: tb/tb_resource_instr_issuer.sv
// ---------------------------------------------------------------------------
// tb_resource_instr_issuer
//
// Exercises resource_instr_issuer with directed scenarios and randomized
// traffic. The reference keeps the buffered entries in a queue and tracks
// the earliest edge at which the next pop is allowed after an activate.
// A second instance built with ACT_GAP = 0 covers adjacent activates.
// ---------------------------------------------------------------------------
module tb_resource_instr_issuer;

   localparam int W     = 27;
   localparam int DEPTH = 4;
   localparam int GAP   = 2;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          inValid;
   logic          inIsAct;
   logic [W-1:0]  inInstr;
   logic          hold;
   logic          inReady;
   logic          instrEn;
   logic [W-1:0]  instr;
   logic          activate;
   logic [2:0]    count;
   logic          idle;

   logic          zValid;
   logic          zIsAct;
   logic [W-1:0]  zInstrIn;
   logic          zHold;
   logic          zReady;
   logic          zEn;
   logic [W-1:0]  zInstr;
   logic          zAct;
   logic [2:0]    zCount;
   logic          zIdle;

   int            nCompared   = 0;
   int            nMismatched = 0;

   logic [W:0]    modelQ[$];
   int            edgeNum;
   int            nextAllowed;
   logic          expEn;
   logic          expAct;
   logic          expInGap;
   logic [W-1:0]  expInstr;
   logic          doPop;
   logic          doPush;
   logic [W:0]    headEntry;

   always #5 clk = ~clk;

   resource_instr_issuer #(
      .RESOURCE_INSTR_WIDTH(W),
      .FIFO_DEPTH(DEPTH),
      .ACT_GAP(GAP)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .in_valid(inValid),
      .in_ready(inReady),
      .in_is_act(inIsAct),
      .in_instr(inInstr),
      .hold(hold),
      .instr_en(instrEn),
      .instr(instr),
      .activate(activate),
      .count(count),
      .idle(idle)
   );

   resource_instr_issuer #(
      .RESOURCE_INSTR_WIDTH(W),
      .FIFO_DEPTH(DEPTH),
      .ACT_GAP(0)
   ) dutGap0 (
      .clk(clk),
      .rst_n(rst_n),
      .in_valid(zValid),
      .in_ready(zReady),
      .in_is_act(zIsAct),
      .in_instr(zInstrIn),
      .hold(zHold),
      .instr_en(zEn),
      .instr(zInstr),
      .activate(zAct),
      .count(zCount),
      .idle(zIdle)
   );

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      nCompared++;
      if (actual !== expected) begin
         nMismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic v, input logic a, input logic [W-1:0] word, input logic h);
      inValid = v;
      inIsAct = a;
      inInstr = word;
      hold    = h;
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   // Drains the FIFO with a bounded wait and pins the quiescent state.
   task automatic drain(input string tag);
      int n;
      applyStimulus(1'b0, 1'b0, '0, 1'b0);
      n = 0;
      while (!(idle && (count == 3'd0)) && (n < 200)) begin
         step();
         n++;
      end
      checkOutput({tag, "_idle"}, 32'(idle), 32'd1);
      checkOutput({tag, "_count"}, 32'(count), 32'd0);
   endtask

   // Reference model: at each edge, pop the head if it is present, hold is
   // low and the post-activate quiet window has expired; push if the queue
   // held fewer than DEPTH entries before the edge. Outputs are checked 1
   // time unit after every edge.
   always @(posedge clk) begin
      if (!rst_n) begin
         modelQ.delete();
         edgeNum     = 0;
         nextAllowed = 0;
         expEn       = 1'b0;
         expAct      = 1'b0;
         expInstr    = '0;
         expInGap    = 1'b0;
      end else begin
         edgeNum++;
         doPop    = (modelQ.size() > 0) && !hold && (edgeNum >= nextAllowed);
         doPush   = inValid && (modelQ.size() < DEPTH);
         expEn    = 1'b0;
         expAct   = 1'b0;
         expInstr = '0;
         if (doPop) begin
            headEntry = modelQ.pop_front();
            if (headEntry[W]) begin
               expAct      = 1'b1;
               nextAllowed = edgeNum + GAP + 1;
            end else begin
               expEn    = 1'b1;
               expInstr = headEntry[W-1:0];
            end
         end
         if (doPush) begin
            modelQ.push_back({inIsAct, inInstr});
         end
         expInGap = (edgeNum + 1 < nextAllowed);
      end
      #1;
      checkOutput("cyc_instr_en", 32'(instrEn), 32'(expEn));
      checkOutput("cyc_instr", 32'(instr), 32'(expInstr));
      checkOutput("cyc_activate", 32'(activate), 32'(expAct));
      checkOutput("cyc_count", 32'(count), 32'(modelQ.size()));
      checkOutput("cyc_in_ready", 32'(inReady), 32'(modelQ.size() < DEPTH));
      checkOutput("cyc_idle", 32'(idle), 32'((modelQ.size() == 0) && !expEn && !expAct && !expInGap));
      checkOutput("cyc_one_hot", 32'(instrEn && activate), 32'd0);
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int sent;
      int guard;
      logic acc;

      rst_n    = 1'b0;
      zValid   = 1'b0;
      zIsAct   = 1'b0;
      zInstrIn = '0;
      zHold    = 1'b0;
      applyStimulus(1'b0, 1'b0, '0, 1'b0);
      repeat (2) step();

      // Reset state
      checkOutput("rst_instr_en", 32'(instrEn), 32'd0);
      checkOutput("rst_instr", 32'(instr), 32'd0);
      checkOutput("rst_activate", 32'(activate), 32'd0);
      checkOutput("rst_count", 32'(count), 32'd0);
      checkOutput("rst_idle", 32'(idle), 32'd1);
      rst_n = 1'b1;
      step();

      // Burst ordering: 1-cycle latency, three consecutive strobes
      applyStimulus(1'b1, 1'b0, 27'h0000001, 1'b0);
      step();
      checkOutput("burst_pre_en", 32'(instrEn), 32'd0);
      checkOutput("burst_pre_instr", 32'(instr), 32'd0);
      applyStimulus(1'b1, 1'b0, 27'h0000002, 1'b0);
      step();
      checkOutput("burst_en0", 32'(instrEn), 32'd1);
      checkOutput("burst_w0", 32'(instr), 32'h0000001);
      applyStimulus(1'b1, 1'b0, 27'h7FFFFFF, 1'b0);
      step();
      checkOutput("burst_w1", 32'(instr), 32'h0000002);
      applyStimulus(1'b0, 1'b0, '0, 1'b0);
      step();
      checkOutput("burst_w2", 32'(instr), 32'h7FFFFFF);
      step();
      checkOutput("burst_post_en", 32'(instrEn), 32'd0);
      checkOutput("burst_post_instr", 32'(instr), 32'd0);

      // Activate gap: A, activate, two quiet cycles, B
      applyStimulus(1'b1, 1'b0, 27'h0000123, 1'b0);
      step();
      applyStimulus(1'b1, 1'b1, 27'h5555555, 1'b0);
      step();
      checkOutput("gap_a_en", 32'(instrEn), 32'd1);
      checkOutput("gap_a_instr", 32'(instr), 32'h0000123);
      applyStimulus(1'b1, 1'b0, 27'h0000456, 1'b0);
      step();
      checkOutput("gap_act", 32'(activate), 32'd1);
      checkOutput("gap_act_en", 32'(instrEn), 32'd0);
      checkOutput("gap_act_instr", 32'(instr), 32'd0);
      applyStimulus(1'b0, 1'b0, '0, 1'b0);
      step();
      checkOutput("gap_q1", 32'({instrEn, activate}), 32'd0);
      step();
      checkOutput("gap_q2", 32'({instrEn, activate}), 32'd0);
      step();
      checkOutput("gap_b_en", 32'(instrEn), 32'd1);
      checkOutput("gap_b_instr", 32'(instr), 32'h0000456);
      drain("gap");

      // Full FIFO under hold, then release
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 1'b0, W'(32'h11 + i), 1'b1);
         step();
      end
      applyStimulus(1'b1, 1'b0, 27'h0000015, 1'b1);
      step();
      checkOutput("full_count", 32'(count), 32'd4);
      checkOutput("full_ready", 32'(inReady), 32'd0);
      checkOutput("full_hold_en", 32'(instrEn), 32'd0);
      applyStimulus(1'b1, 1'b0, 27'h0000015, 1'b0);
      step();
      checkOutput("full_first_pop", 32'(instr), 32'h11);
      checkOutput("full_ready_rise", 32'(inReady), 32'd1);
      checkOutput("full_count_pop", 32'(count), 32'd3);
      step();
      checkOutput("full_second", 32'(instr), 32'h12);
      checkOutput("full_count_pushpop", 32'(count), 32'd3);
      drain("full");

      // Reset mid-burst, asserted between edges
      applyStimulus(1'b1, 1'b0, 27'h00000A1, 1'b0);
      step();
      applyStimulus(1'b1, 1'b0, 27'h00000A2, 1'b0);
      step();
      applyStimulus(1'b1, 1'b0, 27'h00000A3, 1'b0);
      step();
      applyStimulus(1'b0, 1'b0, '0, 1'b0);
      checkOutput("mid_pre_en", 32'(instrEn), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("mid_rst_en", 32'(instrEn), 32'd0);
      checkOutput("mid_rst_instr", 32'(instr), 32'd0);
      checkOutput("mid_rst_act", 32'(activate), 32'd0);
      checkOutput("mid_rst_count", 32'(count), 32'd0);
      step();
      rst_n = 1'b1;
      repeat (3) begin
         step();
         checkOutput("mid_after_en", 32'(instrEn), 32'd0);
         checkOutput("mid_after_idle", 32'(idle), 32'd1);
      end

      // Pointer wrap: 10 instructions with random hold
      sent  = 0;
      guard = 0;
      while ((sent < 10) && (guard < 500)) begin
         applyStimulus(1'b1, 1'b0, W'(32'h100 + sent), 1'($urandom_range(0, 1)));
         acc = inReady;
         step();
         if (acc) begin
            sent++;
         end
         guard++;
      end
      checkOutput("wrap_sent", 32'(sent), 32'd10);
      drain("wrap");

      // Randomized mix of instructions, activates and hold
      for (int i = 0; i < 400; i++) begin
         applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
                       W'($urandom), 1'($urandom_range(0, 3) == 0));
         step();
      end
      drain("rand");

      // ACT_GAP = 0 instance: two activates give adjacent pulses
      zValid = 1'b1;
      zIsAct = 1'b1;
      step();
      checkOutput("z_pre_act", 32'(zAct), 32'd0);
      step();
      zValid = 1'b0;
      zIsAct = 1'b0;
      checkOutput("z_act0", 32'(zAct), 32'd1);
      checkOutput("z_count", 32'(zCount), 32'd1);
      step();
      checkOutput("z_act1", 32'(zAct), 32'd1);
      checkOutput("z_en", 32'(zEn), 32'd0);
      step();
      checkOutput("z_act_end", 32'(zAct), 32'd0);
      checkOutput("z_idle", 32'(zIdle), 32'd1);
      checkOutput("z_instr", 32'(zInstr), 32'd0);

      step();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
